// File: rtl/vga_pkg.sv
// Shared definitions for the VGA text controller bus interface:
// response codes, address-map constants and FSM encodings.
package vga_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int VGA_BUF_LIMIT = 6496;
    localparam int REGION_BIT    = 12;

    typedef enum logic [1:0] {
        W_IDLE,
        W_EXEC,
        W_RESP
    } wstate_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } rstate_e;

endpackage

// File: rtl/vga_axil_decode.sv
// Address-map check: region select bit plus upper range bound,
// shared by the write and read paths.
module vga_axil_decode
    import vga_pkg::*;
#(
    parameter int ADDR_W  = 13,
    parameter int SEL_BIT = REGION_BIT,
    parameter int LIMIT   = VGA_BUF_LIMIT
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic              in_range_o,
    output logic              is_buf_o
);

    localparam logic [ADDR_W:0] LIM = LIMIT[ADDR_W:0];

    assign is_buf_o   = addr_i[SEL_BIT];
    assign in_range_o = {1'b0, addr_i} < LIM;

endmodule

// File: rtl/vga_axil_slave.sv
// AXI4-Lite responder for the VGA text controller: serialises bus
// writes into backend pulses and reads into timed backend requests.
module vga_axil_slave
    import vga_pkg::*;
#(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 13,
    parameter int READ_LATENCY     = 2,
    parameter int BUF_LIMIT        = 6496
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          s_awvalid_i,
    output logic                          s_awready_o,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   s_awaddr_i,
    input  logic                          s_wvalid_i,
    output logic                          s_wready_o,
    input  logic [C_AXI_DATA_WIDTH-1:0]   s_wdata_i,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] s_wstrb_i,
    output logic                          s_bvalid_o,
    input  logic                          s_bready_i,
    output logic [1:0]                    s_bresp_o,
    input  logic                          s_arvalid_i,
    output logic                          s_arready_o,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   s_araddr_i,
    output logic                          s_rvalid_o,
    input  logic                          s_rready_i,
    output logic [C_AXI_DATA_WIDTH-1:0]   s_rdata_o,
    output logic [1:0]                    s_rresp_o,
    output logic [C_AXI_ADDR_WIDTH-1:0]   axil_waddr_o,
    output logic [C_AXI_DATA_WIDTH-1:0]   axil_wdata_o,
    output logic [C_AXI_DATA_WIDTH/8-1:0] axil_wstrb_o,
    output logic                          axil_wready_o,
    output logic [C_AXI_ADDR_WIDTH-1:0]   axil_raddr_o,
    output logic                          axil_rreq_o,
    input  logic [C_AXI_DATA_WIDTH-1:0]   axil_rdata_i
);

    localparam int DW = C_AXI_DATA_WIDTH;
    localparam int AW = C_AXI_ADDR_WIDTH;
    localparam int SW = DW / 8;
    localparam logic [2:0] RL = 3'(READ_LATENCY);

    wstate_e       w_state_q, w_state_d;
    logic          aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [AW-1:0] awaddr_q, awaddr_d, bwaddr_q, bwaddr_d;
    logic [DW-1:0] wdata_q, wdata_d, bwdata_q, bwdata_d;
    logic [SW-1:0] wstrb_q, wstrb_d, bwstrb_q, bwstrb_d;
    logic          awready_q, awready_d, wready_q, wready_d;
    logic          bvalid_q, bvalid_d, wpulse_q, wpulse_d;
    logic [1:0]    bresp_q, bresp_d;

    rstate_e       r_state_q, r_state_d;
    logic          arready_q, arready_d, rvalid_q, rvalid_d;
    logic          rreq_q, rreq_d, rpend_q, rpend_d;
    logic [1:0]    rresp_q, rresp_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic [2:0]    cnt_q, cnt_d;

    logic          aw_take, w_take, ar_take;
    logic [AW-1:0] w_dec_addr;
    logic          w_in_range, w_is_buf, r_in_range, r_is_buf;
    logic          w_ok, r_ok, hazard;

    assign aw_take    = s_awvalid_i && awready_q;
    assign w_take     = s_wvalid_i && wready_q;
    assign ar_take    = s_arvalid_i && arready_q;
    assign w_dec_addr = aw_take ? s_awaddr_i : awaddr_q;

    vga_axil_decode #(
        .ADDR_W (AW),
        .SEL_BIT(AW - 1),
        .LIMIT  (BUF_LIMIT)
    ) u_wdec (
        .addr_i    (w_dec_addr),
        .in_range_o(w_in_range),
        .is_buf_o  (w_is_buf)
    );

    vga_axil_decode #(
        .ADDR_W (AW),
        .SEL_BIT(AW - 1),
        .LIMIT  (BUF_LIMIT)
    ) u_rdec (
        .addr_i    (s_araddr_i),
        .in_range_o(r_in_range),
        .is_buf_o  (r_is_buf)
    );

    assign w_ok   = !w_is_buf || w_in_range;
    assign r_ok   = r_is_buf && r_in_range;
    // A read colliding with this cycle's write pulse waits one cycle
    assign hazard = wpulse_d && (w_dec_addr[AW-1:2] == s_araddr_i[AW-1:2]);

    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bwaddr_d  = bwaddr_q;
        bwdata_d  = bwdata_q;
        bwstrb_d  = bwstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        wpulse_d  = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                if (aw_take) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = s_awaddr_i;
                end
                if (w_take) begin
                    w_held_d = 1'b1;
                    wdata_d  = s_wdata_i;
                    wstrb_d  = s_wstrb_i;
                end
                if (aw_held_d && w_held_d) begin
                    w_state_d = W_EXEC;
                    wpulse_d  = w_ok;
                    if (w_ok) begin
                        bwaddr_d = awaddr_d;
                        bwdata_d = wdata_d;
                        bwstrb_d = wstrb_d;
                    end
                end
            end
            W_EXEC: begin
                w_state_d = W_RESP;
                aw_held_d = 1'b0;
                w_held_d  = 1'b0;
                bvalid_d  = 1'b1;
                bresp_d   = wpulse_q ? RESP_OKAY : RESP_SLVERR;
            end
            W_RESP: begin
                if (s_bready_i) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE) && !aw_held_d;
        wready_d  = (w_state_d == W_IDLE) && !w_held_d;
    end

    always_comb begin
        r_state_d = r_state_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        raddr_d   = raddr_q;
        cnt_d     = cnt_q;
        rreq_d    = 1'b0;
        rpend_d   = 1'b0;
        unique case (r_state_q)
            R_IDLE: begin
                if (ar_take && r_ok) begin
                    r_state_d = R_WAIT;
                    raddr_d   = s_araddr_i;
                    cnt_d     = RL;
                    rpend_d   = hazard;
                    rreq_d    = !hazard;
                end else if (ar_take) begin
                    r_state_d = R_RESP;
                    rvalid_d  = 1'b1;
                    rdata_d   = '0;
                    rresp_d   = RESP_SLVERR;
                end
            end
            R_WAIT: begin
                if (rpend_q) begin
                    rreq_d = 1'b1;
                end else if (cnt_q == 3'd0) begin
                    r_state_d = R_RESP;
                    rvalid_d  = 1'b1;
                    rdata_d   = axil_rdata_i;
                    rresp_d   = RESP_OKAY;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            R_RESP: begin
                if (s_rready_i) begin
                    rvalid_d  = 1'b0;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bwaddr_q  <= '0;
            bwdata_q  <= '0;
            bwstrb_q  <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            wpulse_q  <= 1'b0;
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
            raddr_q   <= '0;
            cnt_q     <= 3'd0;
            rreq_q    <= 1'b0;
            rpend_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bwaddr_q  <= bwaddr_d;
            bwdata_q  <= bwdata_d;
            bwstrb_q  <= bwstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            wpulse_q  <= wpulse_d;
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            raddr_q   <= raddr_d;
            cnt_q     <= cnt_d;
            rreq_q    <= rreq_d;
            rpend_q   <= rpend_d;
        end
    end

    assign s_awready_o   = awready_q;
    assign s_wready_o    = wready_q;
    assign s_bvalid_o    = bvalid_q;
    assign s_bresp_o     = bresp_q;
    assign s_arready_o   = arready_q;
    assign s_rvalid_o    = rvalid_q;
    assign s_rdata_o     = rdata_q;
    assign s_rresp_o     = rresp_q;
    assign axil_waddr_o  = bwaddr_q;
    assign axil_wdata_o  = bwdata_q;
    assign axil_wstrb_o  = bwstrb_q;
    assign axil_wready_o = wpulse_q;
    assign axil_raddr_o  = raddr_q;
    assign axil_rreq_o   = rreq_q;

endmodule
